m_fetch_queue: RTL

- Decoupled instruction-fetch stage for the 5-stage RV32I core.
- Sits between the asynchronous instruction memory and the IfId pipeline register.
- Generates the fetch PC and buffers fetched {pc, ir} pairs in a small circular FIFO.
- Hands one instruction per cycle to decode with a valid/ready handshake, flushing on an Ex-stage branch redirect.

---
 rtl/m_fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/m_fetch_queue.sv
// rtl/m_fetch_queue.sv - decoupled fetch stage: PC generator plus {pc, ir} circular queue toward decode
// Optional feature macro: FETCHQ_BYPASS_EN (empty-queue combinational bypass to decode)
module m_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] HALT_IR  = 32'h000f0033
) (
   input  logic                   w_clk,
   input  logic                   w_rst,
   input  logic                   w_ce,
   output logic [11:0]            w_imem_addr,
   input  logic [31:0]            w_imem_data,
   input  logic                   w_redirect,
   input  logic [31:0]            w_redirect_pc,
   output logic                   w_deq_valid,
   input  logic                   w_deq_ready,
   output logic [31:0]            w_deq_pc,
   output logic [31:0]            w_deq_ir,
   output logic [$clog2(DEPTH):0] w_count,
   output logic                   w_halted
);
   localparam int          AW     = $clog2(DEPTH);
   localparam int          CW     = AW + 1;
   localparam logic [31:0] NOP_IR = 32'h00000013;

   logic [31:0]   r_fpc;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_halted;

   logic [31:0]   w_tgt;
   logic [63:0]   w_head;
   logic          w_empty;
   logic          w_full;
   logic          w_byp_active;
   logic          w_byp_take;
   logic          w_q_deq;
   logic          w_enq;
   logic          w_fetch_halt;

   // Redirect targets are word aligned; the low two bits are simply masked off.
   assign w_tgt        = w_redirect_pc & 32'hffff_fffc;
   assign w_head       = r_mem[r_rptr];
   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_fetch_halt = (w_imem_data == HALT_IR);
   assign w_imem_addr  = r_fpc[13:2];
   assign w_count      = r_count;
   assign w_halted     = r_halted;

`ifdef FETCHQ_BYPASS_EN
   assign w_byp_active = w_empty & ~r_halted & ~w_redirect;
`else
   assign w_byp_active = 1'b0;
`endif

   // A bypassed word that decode takes never enters the array; a refused one is enqueued as usual.
   assign w_byp_take = w_byp_active & w_deq_ready;
   assign w_q_deq    = ~w_empty & w_deq_ready;
   assign w_enq      = ~r_halted & ~w_byp_take & (~w_full | w_q_deq);

   // Decode-side view: bypass word, queue head, or the NOP bubble when nothing is available.
   always_comb begin
      w_deq_valid = 1'b0;
      w_deq_pc    = 32'h0;
      w_deq_ir    = NOP_IR;
      if (w_byp_active) begin
         w_deq_valid = 1'b1;
         w_deq_pc    = r_fpc;
         w_deq_ir    = w_imem_data;
      end else if (!w_empty) begin
         w_deq_valid = 1'b1;
         w_deq_pc    = w_head[63:32];
         w_deq_ir    = w_head[31:0];
      end
   end

   // Queue storage is not reset; occupancy is tracked by the pointers and count alone.
   always_ff @(posedge w_clk) begin
      if (!w_rst && w_ce && !w_redirect && w_enq) begin
         r_mem[r_wptr] <= {r_fpc, w_imem_data};
      end
   end

   // Fetch PC, pointers, occupancy and halt flag: reset beats redirect beats normal flow.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_fpc    <= RESET_PC;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_halted <= 1'b0;
      end else if (w_ce) begin
         if (w_redirect) begin
            r_fpc    <= w_tgt;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
         end else begin
            if (w_enq || w_byp_take) begin
               r_fpc <= r_fpc + 32'd4;
               if (w_fetch_halt) begin
                  r_halted <= 1'b1;
               end
            end
            if (w_enq) begin
               r_wptr <= r_wptr + AW'(1);
            end
            if (w_q_deq) begin
               r_rptr <= r_rptr + AW'(1);
            end
            if (w_enq && !w_q_deq) begin
               r_count <= r_count + CW'(1);
            end else if (!w_enq && w_q_deq) begin
               r_count <= r_count - CW'(1);
            end
         end
      end
   end
endmodule
